// File: rtl/alu_seq_if.sv
// Issue, ALU and result channels of the execute-stage sequencer.
interface alu_seq_if;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_kind;
    logic [1:0]  issue_divop;
    logic [31:0] issue_rs1;
    logic [31:0] issue_rs2;
    logic        alu_enabled;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_rd;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    modport master (
        output issue_valid,
        input  issue_ready,
        output issue_kind,
        output issue_divop,
        output issue_rs1,
        output issue_rs2,
        input  alu_enabled,
        input  alu_rs1,
        input  alu_rs2,
        output alu_rd,
        input  res_valid,
        output res_ready,
        input  res_data
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  issue_kind,
        input  issue_divop,
        input  issue_rs1,
        input  issue_rs2,
        output alu_enabled,
        output alu_rs1,
        output alu_rs2,
        input  alu_rd,
        output res_valid,
        input  res_ready,
        output res_data
    );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage sequencer: drives the combinational ALU for a fixed
// number of cycles and runs div/rem on an iterative radix-2 divider.
module alu_seq #(
    parameter int MUL_LAT = 2,
    parameter int DIV_W   = 32
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     flush,
    output logic     busy,
    alu_seq_if.slave bus
);
    if (DIV_W != 32 || MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_param
        $error("alu_seq: DIV_W must be 32 and MUL_LAT in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [5:0]  div_cnt;
    logic [32:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_dvs;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] res_q;

    logic        accept;
    logic        sgn;
    logic        rs2_zero;
    logic        ovf;
    logic        special;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] spec_res;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign rs1      = bus.issue_rs1;
    assign rs2      = bus.issue_rs2;
    assign accept   = bus.issue_valid & bus.issue_ready & ~flush;
    // divop bit0 selects unsigned, bit1 selects remainder
    assign sgn      = ~bus.issue_divop[0];
    assign abs1     = (sgn & rs1[31]) ? -rs1 : rs1;
    assign abs2     = (sgn & rs2[31]) ? -rs2 : rs2;
    assign rs2_zero = (rs2 == '0);
    assign ovf      = sgn & (rs1 == 32'h8000_0000)
                    & (rs2 == 32'hFFFF_FFFF);
    assign special  = rs2_zero | ovf;

    always_comb begin
        spec_res = '0;
        if (rs2_zero)
            spec_res = bus.issue_divop[1] ? rs1 : 32'hFFFF_FFFF;
        else
            spec_res = bus.issue_divop[1] ? 32'h0 : 32'h8000_0000;
    end

    assign rem_sh  = {div_rem[31:0], div_quo[31]};
    assign diff    = rem_sh - {1'b0, div_dvs};
    assign quo_fix = neg_q ? -div_quo : div_quo;
    assign rem_fix = neg_r ? -div_rem[31:0] : div_rem[31:0];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (bus.issue_kind)
                        2'd0, 2'd1: state_nx = EXEC;
                        2'd2: state_nx = special ? DONE : DIV_RUN;
                        default: state_nx = DONE;
                    endcase
                end
            end
            EXEC:    if (cnt == 4'd0) state_nx = DONE;
            DIV_RUN: if (div_cnt == 6'd31) state_nx = DIV_FIX;
            DIV_FIX: state_nx = DONE;
            DONE:    if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            div_cnt <= '0;
            div_rem <= '0;
            div_quo <= '0;
            div_dvs <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            is_rem  <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rs1_q   <= rs1;
                rs2_q   <= rs2;
                cnt     <= (bus.issue_kind == 2'd1)
                         ? 4'(MUL_LAT - 1) : 4'd0;
                div_cnt <= '0;
                div_rem <= '0;
                div_quo <= abs1;
                div_dvs <= abs2;
                neg_q   <= sgn & (rs1[31] ^ rs2[31]);
                neg_r   <= sgn & rs1[31];
                is_rem  <= bus.issue_divop[1];
                res_q   <= (bus.issue_kind == 2'd2) ? spec_res : 32'h0;
            end else if (!flush) begin
                unique case (state)
                    EXEC: begin
                        if (cnt == 4'd0)
                            res_q <= bus.alu_rd;
                        else
                            cnt <= cnt - 4'd1;
                    end
                    DIV_RUN: begin
                        div_rem <= diff[32] ? rem_sh : diff;
                        div_quo <= {div_quo[30:0], ~diff[32]};
                        div_cnt <= div_cnt + 6'd1;
                    end
                    DIV_FIX: res_q <= is_rem ? rem_fix : quo_fix;
                    default: ;
                endcase
            end
        end
    end

    assign bus.issue_ready = (state == IDLE);
    assign bus.alu_enabled = (state == EXEC);
    assign bus.res_valid   = (state == DONE);
    assign bus.alu_rs1     = rs1_q;
    assign bus.alu_rs2     = rs2_q;
    assign bus.res_data    = res_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: ALU timing, divider, special cases,
// flush and asynchronous reset.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rstn;
    logic flush;
    logic busy;
    logic alu_mul;
    int   n_chk = 0;
    int   n_err = 0;

    alu_seq_if bus();

    alu_seq #(.MUL_LAT(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .flush(flush),
        .busy (busy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.alu_rd = alu_mul ? bus.alu_rs1 * bus.alu_rs2
                                : bus.alu_rs1 + bus.alu_rs2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] kind, input logic [1:0] divop,
                         input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1'b1;
        bus.issue_kind  = kind;
        bus.issue_divop = divop;
        bus.issue_rs1   = a;
        bus.issue_rs2   = b;
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] kind,
                          input logic [1:0] divop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat_exp);
        int lat;
        issue(kind, divop, a, b);
        lat = 1;
        while (!bus.res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_data"}, bus.res_data, exp);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check({tag, "_rdy"}, 32'(bus.issue_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        rstn            = 1'b0;
        flush           = 1'b0;
        alu_mul         = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_kind  = 2'd0;
        bus.issue_divop = 2'd0;
        bus.issue_rs1   = '0;
        bus.issue_rs2   = '0;
        bus.res_ready   = 1'b0;

        #1;
        check("rst_rdy", 32'(bus.issue_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'(bus.res_valid), 32'd0);
        check("rst_en", 32'(bus.alu_enabled), 32'd0);
        check("rst_data", bus.res_data, 32'd0);
        check("rst_rs1", bus.alu_rs1, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // kind 0: one enable cycle, result two cycles after accept
        issue(2'd0, 2'd0, 32'd5, 32'd7);
        check("add_en1", 32'(bus.alu_enabled), 32'd1);
        check("add_rdy1", 32'(bus.issue_ready), 32'd0);
        check("add_vld1", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("add_en2", 32'(bus.alu_enabled), 32'd0);
        check("add_vld2", 32'(bus.res_valid), 32'd1);
        check("add_data", bus.res_data, 32'd12);
        check("add_rdy2", 32'(bus.issue_ready), 32'd0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("add_vld3", 32'(bus.res_valid), 32'd0);
        check("add_rdy3", 32'(bus.issue_ready), 32'd1);

        // kind 1 with MUL_LAT=3 and backpressure
        alu_mul = 1'b1;
        issue(2'd1, 2'd0, 32'd6, 32'd7);
        for (int i = 0; i < 3; i++) begin
            check("mul_en", 32'(bus.alu_enabled), 32'd1);
            check("mul_vld_lo", 32'(bus.res_valid), 32'd0);
            @(negedge clk);
        end
        check("mul_en_off", 32'(bus.alu_enabled), 32'd0);
        check("mul_vld", 32'(bus.res_valid), 32'd1);
        check("mul_data", bus.res_data, 32'd42);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_hold_vld", 32'(bus.res_valid), 32'd1);
            check("mul_hold", bus.res_data, 32'd42);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("mul_vld_end", 32'(bus.res_valid), 32'd0);
        check("mul_rdy_end", 32'(bus.issue_ready), 32'd1);
        alu_mul = 1'b0;

        run_op("div_m7_2", 2'd2, 2'd0, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", 2'd2, 2'd2, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 34);
        run_op("div_7_m2", 2'd2, 2'd0, 32'd7, 32'hFFFF_FFFE,
               32'hFFFF_FFFD, 34);
        run_op("rem_7_m2", 2'd2, 2'd2, 32'd7, 32'hFFFF_FFFE,
               32'd1, 34);
        run_op("divu_100_7", 2'd2, 2'd1, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", 2'd2, 2'd3, 32'd100, 32'd7, 32'd2, 34);
        run_op("divu_max_1", 2'd2, 2'd1, 32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, 34);
        run_op("div_by0", 2'd2, 2'd0, 32'd123, 32'd0,
               32'hFFFF_FFFF, 1);
        run_op("remu_by0", 2'd2, 2'd3, 32'd123, 32'd0, 32'd123, 1);
        run_op("div_ovf", 2'd2, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1);
        run_op("rem_ovf", 2'd2, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 1);
        run_op("kind3", 2'd3, 2'd0, 32'd9, 32'd9, 32'd0, 1);

        // flush during divider iteration 10
        issue(2'd2, 2'd0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("fl_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_idle", 32'(busy), 32'd0);
        check("fl_rdy", 32'(bus.issue_ready), 32'd1);
        check("fl_vld", 32'(bus.res_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check("fl_no_vld", 32'(seen), 32'd0);
        run_op("after_fl", 2'd0, 2'd0, 32'd1, 32'd2, 32'd3, 2);

        flush = 1'b1;
        issue(2'd0, 2'd0, 32'd99, 32'd1);
        flush = 1'b0;
        check("fl_iss_rdy", 32'(bus.issue_ready), 32'd1);
        check("fl_iss_busy", 32'(busy), 32'd0);
        check("fl_iss_en", 32'(bus.alu_enabled), 32'd0);
        check("fl_iss_rs1", bus.alu_rs1, 32'd1);

        // asynchronous reset while the divider is running
        issue(2'd2, 2'd0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("ar_busy_pre", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_rdy", 32'(bus.issue_ready), 32'd1);
        check("ar_vld", 32'(bus.res_valid), 32'd0);
        check("ar_rs1", bus.alu_rs1, 32'd0);
        check("ar_rs2", bus.alu_rs2, 32'd0);
        check("ar_data", bus.res_data, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_op("post_rst", 2'd0, 2'd0, 32'd5, 32'd7, 32'd12, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
